// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package kbd_pkg;

    // Frame decoder states: start bit seen in IDLE, then 8 data, parity, stop.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PREFIX_E0 = 8'hE0;  // extended-key prefix
    localparam logic [7:0] PREFIX_F0 = 8'hF0;  // break (release) prefix

    localparam int ENTRY_W = 10;

    // Queued key entry; packing order matches {ext, brk, code}.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } entry_t;

    // PS/2 uses odd parity over data plus parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// First-word-fall-through FIFO holding decoded key entries.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: push into full without a pop is dropped and flagged on drop.
//
// Ports: clk/reset (sync, active high); push/push_dat write side;
// pop consumes the head; head_dat/head_vld show the oldest entry;
// count is occupancy; drop is a combinational "push lost" strobe.
module kbd_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     head_vld,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra bit so full and empty stay distinguishable;
    // the low AW bits index storage, i.e. wrap modulo DEPTH.
    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (AW+1)'(DEPTH));
    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    assign do_pop  = pop && head_vld;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/kbd_receiver.sv
// PS/2 keyboard receiver: filters ps2clk, decodes frames, folds E0/F0 prefixes, queues keys.
// Latency: key entry valid 1 cycle after the (filtered) stop-bit falling edge.
// Backpressure: valid/ready on the queue head; a full queue drops new keys and pulses overflow.
//
// Ports: clk, reset (sync, active high); ps2clk/ps2data raw async lines;
// code/ext/brk/valid head entry, ready consumer accept, count occupancy;
// frame_err pulses on a discarded frame, overflow on a dropped key.
module kbd_receiver
    import kbd_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 2500
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2clk,
    input  logic                          ps2data,
    output logic [7:0]                    code,
    output logic                          ext,
    output logic                          brk,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int HIST_W = 2 * FILTER_LEN;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [HIST_W-1:0] FALL_PAT = {{FILTER_LEN{1'b1}}, {FILTER_LEN{1'b0}}};

    // Synchronisers reset to 1: an idle PS/2 bus floats high.
    logic [1:0]        clk_sync;
    logic [1:0]        data_sync;
    logic [HIST_W-1:0] hist;
    logic              fall;
    logic              data_bit;

    frame_state_t      state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              parity_bit;
    logic [CNT_W-1:0]  to_cnt;
    logic              ext_pending;
    logic              brk_pending;
    logic              frame_err_q;
    logic              overflow_q;

    logic              frame_ok;
    logic              timed_out;
    logic              push;
    entry_t            push_ent;
    entry_t            head_ent;
    logic              head_vld;
    logic              pop;
    logic              drop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            hist      <= '1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2clk};
            data_sync <= {data_sync[0], ps2data};
            // Newest sample enters at bit 0, so the MSB end is the oldest.
            hist      <= {hist[HIST_W-2:0], clk_sync[1]};
        end
    end

    assign fall     = (hist == FALL_PAT);
    assign data_bit = data_sync[1];

    always_comb begin
        frame_ok  = data_bit && odd_parity_ok(shift, parity_bit);
        // A real edge on the same cycle wins over the timeout.
        timed_out = (state != ST_IDLE) && !fall && (to_cnt == CNT_W'(TIMEOUT));
        push      = fall && (state == ST_STOP) && frame_ok
                    && (shift != PREFIX_E0) && (shift != PREFIX_F0);
        push_ent.ext  = ext_pending;
        push_ent.brk  = brk_pending;
        push_ent.code = shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            parity_bit  <= 1'b0;
            to_cnt      <= '0;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (state == ST_IDLE || fall) to_cnt <= '0;
            else                          to_cnt <= to_cnt + 1'b1;

            if (timed_out) begin
                state       <= ST_IDLE;
                frame_err_q <= 1'b1;
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        // A high sample here is line noise, not a start bit.
                        if (!data_bit) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {data_bit, shift[7:1]};  // LSB arrives first
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        parity_bit <= data_bit;
                        state      <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!frame_ok) begin
                            frame_err_q <= 1'b1;
                            ext_pending <= 1'b0;
                            brk_pending <= 1'b0;
                        end else if (shift == PREFIX_E0) begin
                            ext_pending <= 1'b1;
                        end else if (shift == PREFIX_F0) begin
                            brk_pending <= 1'b1;
                        end else begin
                            // Prefixes are consumed even if the entry is dropped.
                            ext_pending <= 1'b0;
                            brk_pending <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign pop = valid && ready;

    kbd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .head_vld (head_vld),
        .count    (fifo_count),
        .drop     (drop)
    );

    always_ff @(posedge clk) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= drop;
    end

    // Outputs are forced quiet while reset is held, including the first
    // reset cycle before the registers have been cleared.
    assign valid     = head_vld && !reset;
    assign code      = valid ? head_ent.code : 8'h00;
    assign ext       = valid ? head_ent.ext  : 1'b0;
    assign brk       = valid ? head_ent.brk  : 1'b0;
    assign count     = reset ? '0 : fifo_count;
    assign frame_err = frame_err_q && !reset;
    assign overflow  = overflow_q && !reset;

endmodule
